// File: rtl/mem_resp_sram_pkg.sv
// Shared constants and state encoding for the SRAM-backed memory responder.
package mem_resp_sram_pkg;

  localparam int CPU_WIDTH = 32;
  localparam int MASK_W    = CPU_WIDTH / 8;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/mem_resp_sram_array.sv
// Single-port word array with per-byte write enables and registered read data.
module mem_resp_sram_array
  import mem_resp_sram_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 en,
  input  logic [MASK_W-1:0]    we,
  input  logic [AW-1:0]        addr,
  input  logic [CPU_WIDTH-1:0] wdata,
  output logic [CPU_WIDTH-1:0] rdata
);

  logic [CPU_WIDTH-1:0] mem [DEPTH];

  // Read returns the pre-write word; the responder only uses it for loads.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < MASK_W; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_resp_sram.sv
// Memory-side load/store responder: one request in flight, fixed access latency,
// byte-masked stores and full-word loads on an internal synchronous array.
//
// state  | meaning
// IDLE   | ready for a request; latches it on i_req_valid
// WAIT   | latency down-counter running
// ACCESS | array enabled for one cycle (skipped when out of range)
// RESP   | response held until i_rsp_ready
module mem_resp_sram
  import mem_resp_sram_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic                 i_req_wen,
  input  logic [CPU_WIDTH-1:0] i_req_addr,
  input  logic [CPU_WIDTH-1:0] i_req_wdata,
  input  logic [MASK_W-1:0]    i_req_wmask,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [CPU_WIDTH-1:0] o_rsp_rdata,
  output logic                 o_rsp_err
);

  localparam int AW = $clog2(DEPTH);

  state_e               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic                 wen_q;
  logic                 err_q;
  logic [AW-1:0]        idx_q;
  logic [CPU_WIDTH-1:0] wdata_q;
  logic [MASK_W-1:0]    wmask_q;
  logic [CPU_WIDTH-1:0] offset;
  logic                 in_range;
  logic                 accept;
  logic [CPU_WIDTH-1:0] arr_rdata;
  logic                 arr_en;
  logic [MASK_W-1:0]    arr_we;

  // Unsigned subtract: addresses below the base wrap to a huge offset.
  assign offset   = i_req_addr - BASE_ADDR;
  assign in_range = (offset >> 2) < 32'(DEPTH);
  assign accept   = (state == ST_IDLE) && i_req_valid;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      wen_q   <= i_req_wen;
      err_q   <= !in_range;
      idx_q   <= offset[AW+1:2];
      wdata_q <= i_req_wdata;
      wmask_q <= i_req_wmask;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (i_req_valid) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = (LATENCY > 1) ? ST_WAIT : ST_ACCESS;
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1)) state_nxt = ST_ACCESS;
      end
      ST_ACCESS: state_nxt = ST_RESP;
      ST_RESP: begin
        if (i_rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign arr_en = (state == ST_ACCESS) && !err_q;
  assign arr_we = wen_q ? wmask_q : '0;

  mem_resp_sram_array #(.DEPTH(DEPTH)) u_array (
    .clk   (i_clk),
    .en    (arr_en),
    .we    (arr_we),
    .addr  (idx_q),
    .wdata (wdata_q),
    .rdata (arr_rdata)
  );

  // Array read register is not re-enabled during RESP, so rdata holds stable.
  assign o_req_ready = (state == ST_IDLE);
  assign o_rsp_valid = (state == ST_RESP);
  assign o_rsp_err   = o_rsp_valid && err_q;
  assign o_rsp_rdata = (o_rsp_valid && !wen_q && !err_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_mem_resp_sram.sv
// Directed scoreboard bench for mem_resp_sram (LATENCY=2 main instance, LATENCY=1 streaming instance).
module tb_mem_resp_sram;
  import mem_resp_sram_pkg::*;

  localparam int          DEPTH_A = 1024;
  localparam int          LAT_A   = 2;
  localparam int          DEPTH_B = 16;
  localparam int          LAT_B   = 1;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          NB      = 7;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;

  logic a_req_valid, a_req_ready, a_req_wen, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [3:0]  a_req_wmask;
  logic b_req_valid, b_req_ready, b_req_wen, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [3:0]  b_req_wmask;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic [31:0] model_a [int];
  logic [31:0] model_b [int];
  req_t b_tab [NB];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_resp_sram #(.DEPTH(DEPTH_A), .LATENCY(LAT_A), .BASE_ADDR(BASE)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_wen(a_req_wen),
    .i_req_addr(a_req_addr), .i_req_wdata(a_req_wdata), .i_req_wmask(a_req_wmask),
    .o_rsp_valid(a_rsp_valid), .i_rsp_ready(a_rsp_ready),
    .o_rsp_rdata(a_rsp_rdata), .o_rsp_err(a_rsp_err)
  );

  mem_resp_sram #(.DEPTH(DEPTH_B), .LATENCY(LAT_B), .BASE_ADDR(BASE)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_wen(b_req_wen),
    .i_req_addr(b_req_addr), .i_req_wdata(b_req_wdata), .i_req_wmask(b_req_wmask),
    .o_rsp_valid(b_rsp_valid), .i_rsp_ready(b_rsp_ready),
    .o_rsp_rdata(b_rsp_rdata), .o_rsp_err(b_rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  // One request on instance A; hold = cycles to keep i_rsp_ready low once valid appears.
  task automatic req_a(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wmask, input int hold, input string tag);
    exp_t e;
    logic [31:0] off, rd0, old;
    int k, t_acc, n;
    off = addr - BASE;
    e.rdata = '0;
    e.err   = 1'b1;
    if ((off >> 2) < 32'(DEPTH_A)) begin
      k = int'(off >> 2);
      e.err = 1'b0;
      old = model_a.exists(k) ? model_a[k] : 32'hx;
      if (wen) model_a[k] = merge(old, wdata, wmask);
      else     e.rdata = old;
    end
    sb_a.push_back(e);

    @(negedge clk);
    a_req_valid = 1'b1; a_req_wen = wen; a_req_addr = addr;
    a_req_wdata = wdata; a_req_wmask = wmask; a_rsp_ready = (hold == 0);
    n = 0;
    while (a_req_ready !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_accept"}, 32'(a_req_ready), 32'd1);
    t_acc = cyc;
    @(posedge clk); #1;
    a_req_valid = 1'b0;

    n = 0;
    while (a_rsp_valid !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    chk({tag, "_lat"}, 32'(cyc - t_acc), 32'(LAT_A + 1));
    rd0 = a_rsp_rdata;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_bp_valid"}, 32'(a_rsp_valid), 32'd1);
      chk({tag, "_bp_rdata"}, a_rsp_rdata, rd0);
      chk({tag, "_bp_ready"}, 32'(a_req_ready), 32'd0);
      @(negedge clk);
    end
    a_rsp_ready = 1'b1;
    e = sb_a.pop_front();
    chk({tag, "_rdata"}, a_rsp_rdata, e.rdata);
    chk({tag, "_err"}, 32'(a_rsp_err), 32'(e.err));
    chk({tag, "_busy"}, 32'(a_req_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_done_valid"}, 32'(a_rsp_valid), 32'd0);
    chk({tag, "_done_ready"}, 32'(a_req_ready), 32'd1);
  endtask

  initial begin
    exp_t e;
    logic [31:0] off, old;
    int k, nxt, got, last_acc;

    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_wen = 1'b0; a_req_addr = '0; a_req_wdata = '0;
    a_req_wmask = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_wen = 1'b0; b_req_addr = '0; b_req_wdata = '0;
    b_req_wmask = '0; b_rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(a_req_ready), 32'd1);
    chk("rst_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst_rdata", a_rsp_rdata, 32'd0);
    chk("rst_err", 32'(a_rsp_err), 32'd0);
    rst_n = 1'b1;

    req_a(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, "st10");
    req_a(1'b0, 32'h8000_0010, 32'h0,         4'h0, 0, "ld10");

    req_a(1'b1, 32'h8000_0020, 32'h1122_3344, 4'hF, 0, "pre20");
    req_a(1'b1, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 0, "part20");
    req_a(1'b0, 32'h8000_0020, 32'h0,         4'h0, 0, "ld20");
    chk("part20_model", model_a[8], 32'h11BB_33DD);
    req_a(1'b1, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 0, "st20_nomask");
    req_a(1'b0, 32'h8000_0020, 32'h0,         4'h0, 0, "ld20_nomask");

    req_a(1'b1, 32'h8000_0FFC, 32'h5A5A_5A5A, 4'hF, 0, "pre_last");
    req_a(1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 0, "pre_w0");
    req_a(1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, 0, "oor_below");
    req_a(1'b1, 32'h8000_1000, 32'hFFFF_FFFF, 4'hF, 0, "oor_above");
    req_a(1'b0, 32'h8000_0FFC, 32'h0,         4'h0, 0, "ld_last");
    req_a(1'b0, 32'h8000_0000, 32'h0,         4'h0, 0, "ld_w0");

    req_a(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, "bp");
    req_a(1'b0, 32'h8000_0020, 32'h0, 4'h0, 0, "after_bp");

    // Reset during WAIT of a store: it must never reach the array.
    req_a(1'b1, 32'h8000_0040, 32'h0, 4'hF, 0, "pre40");
    @(negedge clk);
    a_req_valid = 1'b1; a_req_wen = 1'b1; a_req_addr = 32'h8000_0040;
    a_req_wdata = 32'hFFFF_FFFF; a_req_wmask = 4'hF;
    chk("rst40_accept", 32'(a_req_ready), 32'd1);
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst40_valid", 32'(a_rsp_valid), 32'd0);
    chk("rst40_ready", 32'(a_req_ready), 32'd1);
    repeat (LAT_A + 3) @(negedge clk);
    chk("rst40_noresp", 32'(a_rsp_valid), 32'd0);
    req_a(1'b0, 32'h8000_0040, 32'h0, 4'h0, 0, "ld40");

    // Instance B streams requests back-to-back with i_rsp_ready held high.
    b_tab[0] = '{1'b1, 32'h8000_0000, 32'h1111_1111, 4'hF};
    b_tab[1] = '{1'b1, 32'h8000_0004, 32'h2222_2222, 4'hF};
    b_tab[2] = '{1'b1, 32'h8000_0004, 32'hAABB_CCDD, 4'b0011};
    b_tab[3] = '{1'b0, 32'h8000_0000, 32'h0, 4'h0};
    b_tab[4] = '{1'b0, 32'h8000_0004, 32'h0, 4'h0};
    b_tab[5] = '{1'b0, 32'h8000_0040, 32'h0, 4'h0};
    b_tab[6] = '{1'b1, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF};

    @(negedge clk);
    nxt = 0; got = 0; last_acc = -1;
    b_req_valid = 1'b1; b_req_wen = b_tab[0].wen; b_req_addr = b_tab[0].addr;
    b_req_wdata = b_tab[0].wdata; b_req_wmask = b_tab[0].wmask;
    for (int it = 0; it < 200 && got < NB; it++) begin
      @(negedge clk);
      if (b_rsp_valid === 1'b1) begin
        e = sb_b.pop_front();
        chk($sformatf("b_rdata%0d", got), b_rsp_rdata, e.rdata);
        chk($sformatf("b_err%0d", got), 32'(b_rsp_err), 32'(e.err));
        got++;
      end
      if (b_req_valid && b_req_ready === 1'b1) begin
        if (last_acc >= 0) chk($sformatf("b_spacing%0d", nxt), 32'(cyc - last_acc), 32'(LAT_B + 2));
        last_acc = cyc;
        off = b_tab[nxt].addr - BASE;
        e.rdata = '0;
        e.err   = 1'b1;
        if ((off >> 2) < 32'(DEPTH_B)) begin
          k = int'(off >> 2);
          e.err = 1'b0;
          old = model_b.exists(k) ? model_b[k] : 32'hx;
          if (b_tab[nxt].wen) model_b[k] = merge(old, b_tab[nxt].wdata, b_tab[nxt].wmask);
          else                e.rdata = old;
        end
        sb_b.push_back(e);
        nxt++;
        @(posedge clk); #1;
        if (nxt < NB) begin
          b_req_wen = b_tab[nxt].wen; b_req_addr = b_tab[nxt].addr;
          b_req_wdata = b_tab[nxt].wdata; b_req_wmask = b_tab[nxt].wmask;
        end else begin
          b_req_valid = 1'b0;
        end
      end
    end
    chk("b_resp_count", 32'(got), 32'(NB));
    chk("b_model_w1", model_b[1], 32'h2222_CCDD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
